// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter: synchronise/debounce three interrupt buttons, latch pending requests, fixed-priority issue with guard interval.
// Build option: define IRQ_NESTING_EN to let a higher pending line preempt a lower in-service line.
module interrupt_arbiter #(
    parameter int DEBOUNCE = 4,
    parameter int GUARD    = 3
) (
    input  logic       clock,
    input  logic       resetButton,
    input  logic [2:0] request,
    input  logic       interruptEnd,
    output logic       interrupted,
    output logic [2:0] interruptOut,
    output logic [2:0] pending,
    output logic       spuriousEnd
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GUARD} state_t;

    state_t          state_q, state_d;
    logic [2:0]      sync1_q, sync2_q, deb_q, deb_d, deb_prev_q;
    logic [2:0][3:0] cnt_q, cnt_d;
    logic [2:0]      pend_q, pend_d, svc_q, svc_d, out_q, out_d, sel_q, sel_d;
    logic [2:0]      gcnt_q, gcnt_d;
    logic            spur_q, spur_d;
    logic [2:0]      rise, hi_pend, hi_svc, end_clr;
    logic            can_issue;

    function automatic logic [2:0] hi1(input logic [2:0] v);
        return v[2] ? 3'b100 : v[1] ? 3'b010 : v[0] ? 3'b001 : 3'b000;
    endfunction

    assign rise    = deb_q & ~deb_prev_q;
    assign hi_pend = hi1(pend_q);
    assign hi_svc  = hi1(svc_q);
    assign end_clr = interruptEnd ? hi_svc : 3'b000;

`ifdef IRQ_NESTING_EN
    // One-hot values compare numerically in priority order; an empty in-service set is 0.
    assign can_issue = hi_pend > hi_svc;
`else
    assign can_issue = (svc_q == 3'b000) && (pend_q != 3'b000);
`endif

    // Debounce: count consecutive mismatches, toggle the debounced level on the last one.
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = 4'd0;
            end else if (cnt_q[i] == 4'(DEBOUNCE - 1)) begin
                cnt_d[i] = 4'd0;
                deb_d[i] = ~deb_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 4'd1;
            end
        end
    end

    // Arbitration FSM, pending/in-service bookkeeping and retire handling.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gcnt_d  = gcnt_q;
        svc_d   = svc_q & ~end_clr;
        pend_d  = pend_q | rise;
        spur_d  = spur_q | (interruptEnd && svc_q == 3'b000);
        case (state_q)
            S_IDLE: begin
                if (can_issue && !interruptEnd) begin
                    state_d = S_ISSUE;
                    sel_d   = hi_pend;
                end
            end
            S_ISSUE: begin
                svc_d   = (svc_q & ~end_clr) | sel_q;
                pend_d  = (pend_q & ~sel_q) | rise;
                gcnt_d  = 3'd0;
                state_d = S_GUARD;
            end
            S_GUARD: begin
                if (gcnt_q == 3'(GUARD - 1)) state_d = S_IDLE;
                else gcnt_d = gcnt_q + 3'd1;
            end
            default: state_d = S_IDLE;
        endcase
        out_d = hi1(svc_d);
    end

    // State registers; reset drops everything at once, abandoning any issue in progress.
    always_ff @(posedge clock or negedge resetButton) begin
        if (!resetButton) begin
            state_q    <= S_IDLE;
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            cnt_q      <= '0;
            pend_q     <= '0;
            svc_q      <= '0;
            out_q      <= '0;
            sel_q      <= '0;
            gcnt_q     <= '0;
            spur_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= request;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            svc_q      <= svc_d;
            out_q      <= out_d;
            sel_q      <= sel_d;
            gcnt_q     <= gcnt_d;
            spur_q     <= spur_d;
        end
    end

    assign interrupted  = (state_q == S_ISSUE);
    assign interruptOut = out_q;
    assign pending      = pend_q;
    assign spuriousEnd  = spur_q;
endmodule

// File: tb/tb_interrupt_arbiter.sv
// tb_interrupt_arbiter: directed checks of debounce latency, bounce rejection, nesting/non-nesting, spurious end and reset.
module tb_interrupt_arbiter;
    logic       clock = 1'b0;
    logic       resetButton = 1'b0;
    logic [2:0] request = 3'b000;
    logic       interruptEnd = 1'b0;
    logic       interrupted;
    logic [2:0] interruptOut, pending;
    logic       spuriousEnd;
    int         checks = 0;
    int         errors = 0;

    interrupt_arbiter #(.DEBOUNCE(4), .GUARD(3)) dut (
        .clock(clock), .resetButton(resetButton), .request(request), .interruptEnd(interruptEnd),
        .interrupted(interrupted), .interruptOut(interruptOut), .pending(pending), .spuriousEnd(spuriousEnd)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic end_pulse();
        interruptEnd = 1'b1;
        tick();
        interruptEnd = 1'b0;
    endtask

    initial begin
        #1;
        check("reset_interrupted", {2'b0, interrupted}, 3'b000);
        check("reset_out", interruptOut, 3'b000);
        check("reset_pending", pending, 3'b000);
        check("reset_spurious", {2'b0, spuriousEnd}, 3'b000);
        ticks(2);
        resetButton = 1'b1;
        // Single request on line 0: pending at edge 7, pulse after edge 8, in service at edge 9.
        request = 3'b001;
        ticks(7);
        check("t1_pending_e7", pending, 3'b001);
        check("t1_no_pulse_e7", {2'b0, interrupted}, 3'b000);
        tick();
        check("t1_pulse_e8", {2'b0, interrupted}, 3'b001);
        check("t1_out_e8", interruptOut, 3'b000);
        tick();
        check("t1_pulse_done_e9", {2'b0, interrupted}, 3'b000);
        check("t1_out_e9", interruptOut, 3'b001);
        check("t1_pending_e9", pending, 3'b000);
        end_pulse();
        check("t1_retired", interruptOut, 3'b000);
        // Bounce on line 1: high 2, low 1, high held.
        request = 3'b011;
        tick();
        check("t2_bounce_pend_b1", {2'b0, pending[1]}, 3'b000);
        tick();
        check("t2_bounce_pend_b2", {2'b0, pending[1]}, 3'b000);
        request = 3'b001;
        tick();
        check("t2_bounce_pend_b3", {2'b0, pending[1]}, 3'b000);
        request = 3'b011;
        for (int i = 4; i <= 9; i++) begin
            tick();
            check("t2_bounce_pend", {2'b0, pending[1]}, 3'b000);
        end
        tick();
        check("t2_pending_b10", pending, 3'b010);
        tick();
        check("t2_pulse_b11", {2'b0, interrupted}, 3'b001);
        tick();
        check("t2_out_b12", interruptOut, 3'b010);
        begin
            int pulses = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (interrupted) pulses++;
            end
            check("t2_single_issue", 3'(pulses), 3'd0);
        end
        end_pulse();
        check("t2_retired", interruptOut, 3'b000);
        // Line 0 in service, then line 2 rises.
        request = 3'b000;
        ticks(12);
        request = 3'b001;
        ticks(7);
        check("t3_pending0", pending, 3'b001);
        tick();
        check("t3_pulse0", {2'b0, interrupted}, 3'b001);
        tick();
        check("t3_out0", interruptOut, 3'b001);
        request = 3'b101;
        ticks(7);
        check("t3_pending2", pending, 3'b100);
`ifdef IRQ_NESTING_EN
        tick();
        check("t3n_preempt_pulse", {2'b0, interrupted}, 3'b001);
        tick();
        check("t3n_out2", interruptOut, 3'b100);
        check("t3n_pending_clr", pending, 3'b000);
        end_pulse();
        check("t3n_back_to0", interruptOut, 3'b001);
        end_pulse();
        check("t3n_all_retired", interruptOut, 3'b000);
`else
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_no_preempt", {2'b0, interrupted}, 3'b000);
        end
        check("t3_pending_held", pending, 3'b100);
        check("t3_out_held", interruptOut, 3'b001);
        end_pulse();
        check("t3_end_out", interruptOut, 3'b000);
        check("t3_end_no_issue", {2'b0, interrupted}, 3'b000);
        tick();
        check("t3_late_pulse", {2'b0, interrupted}, 3'b001);
        tick();
        check("t3_out2", interruptOut, 3'b100);
        check("t3_pending_clr", pending, 3'b000);
        end_pulse();
        check("t3_all_retired", interruptOut, 3'b000);
`endif
        // Spurious end with nothing in service.
        ticks(4);
        end_pulse();
        check("t5_spurious_set", {2'b0, spuriousEnd}, 3'b001);
        check("t5_out", interruptOut, 3'b000);
        check("t5_pending", pending, 3'b000);
        ticks(3);
        check("t5_spurious_sticky", {2'b0, spuriousEnd}, 3'b001);
        check("t5_no_pulse", {2'b0, interrupted}, 3'b000);
        // Reset during GUARD with line 1 pending behind line 2.
        request = 3'b000;
        ticks(12);
        request = 3'b110;
        ticks(7);
        check("t6_pending_both", pending, 3'b110);
        tick();
        check("t6_pulse2", {2'b0, interrupted}, 3'b001);
        tick();
        check("t6_pending1", pending, 3'b010);
        check("t6_out2", interruptOut, 3'b100);
        #2;
        resetButton = 1'b0;
        request = 3'b000;
        #1;
        check("t6_rst_interrupted", {2'b0, interrupted}, 3'b000);
        check("t6_rst_out", interruptOut, 3'b000);
        check("t6_rst_pending", pending, 3'b000);
        check("t6_rst_spurious", {2'b0, spuriousEnd}, 3'b000);
        ticks(3);
        resetButton = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("t6_no_issue", {2'b0, interrupted}, 3'b000);
        end
        check("t6_pending_final", pending, 3'b000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
